// File: rtl/div_unit_pkg.sv
// Shared types for the RV32M divide unit: operand word, divide-op select and iteration count.
`timescale 1ns/1ps
package div_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    CONTROL_DIV_OP_DIV  = 2'd0,
    CONTROL_DIV_OP_DIVU = 2'd1,
    CONTROL_DIV_OP_REM  = 2'd2,
    CONTROL_DIV_OP_REMU = 2'd3
  } control_div_op_e;

  localparam int DIV_ITERATIONS = 32;

  // Two's-complement magnitude for signed ops; raw word for unsigned ops.
  function automatic word_t abs_word(input word_t x, input logic is_signed);
    return (is_signed && x[31]) ? word_t'(-x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor, set quo[0].
`timescale 1ns/1ps
module div_step
  import div_unit_pkg::*;
(
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);

  logic [33:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_ge;

  assign w_rem_sh = {rem_i, quo_i[31]};
  assign w_ge     = (w_rem_sh >= {2'b00, divisor_i});
  // When w_ge holds, the difference is below the divisor and fits in 33 bits.
  assign w_diff   = w_rem_sh[32:0] - {1'b0, divisor_i};
  assign rem_o    = w_ge ? w_diff : w_rem_sh[32:0];
  assign quo_o    = {quo_i[30:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle, with flush support.
// Optional build macro DIV_UNIT_FAST_ZERO_EN: a zero divisor skips CALC and finishes in one cycle.
`timescale 1ns/1ps
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [1:0]  ctrl_div_op_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          r_state;
  control_div_op_e r_op;
  logic            r_a_neg;
  logic            r_b_neg;
  logic            r_b_zero;
  logic [32:0]     r_rem;
  logic [31:0]     r_quo;
  logic [31:0]     r_divisor;
  logic [4:0]      r_cnt;
  logic            r_busy;
  logic            r_valid;
  logic [31:0]     r_result;

  control_div_op_e w_op;
  logic            w_signed;
  logic [32:0]     w_rem_n;
  logic [31:0]     w_quo_n;

  assign w_op     = control_div_op_e'(ctrl_div_op_i);
  assign w_signed = (w_op == CONTROL_DIV_OP_DIV) || (w_op == CONTROL_DIV_OP_REM);

  div_step u_div_step (
    .rem_i     (r_rem),
    .quo_i     (r_quo),
    .divisor_i (r_divisor),
    .rem_o     (w_rem_n),
    .quo_o     (w_quo_n)
  );

  // A zero divisor yields quo=all-ones and rem=|dividend| naturally, so only sign
  // handling is needed here; DIV skips negation when the divisor is zero.
  function automatic logic [31:0] fixup(input control_div_op_e op, input logic [31:0] rem,
                                        input logic [31:0] quo, input logic a_neg,
                                        input logic b_neg, input logic b_zero);
    logic [31:0] res;
    case (op)
      CONTROL_DIV_OP_DIV:  res = ((a_neg ^ b_neg) && !b_zero) ? (32'd0 - quo) : quo;
      CONTROL_DIV_OP_REM:  res = a_neg ? (32'd0 - rem) : rem;
      CONTROL_DIV_OP_DIVU: res = quo;
      default:             res = rem;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= S_IDLE;
      r_op      <= CONTROL_DIV_OP_DIV;
      r_a_neg   <= 1'b0;
      r_b_neg   <= 1'b0;
      r_b_zero  <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_result  <= '0;
    end else begin
      r_valid <= 1'b0;
      if (flush_i) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_op      <= w_op;
              r_a_neg   <= w_signed & a_i[31];
              r_b_neg   <= w_signed & b_i[31];
              r_b_zero  <= (b_i == 32'd0);
              r_rem     <= '0;
              r_quo     <= abs_word(a_i, w_signed);
              r_divisor <= abs_word(b_i, w_signed);
              r_cnt     <= '0;
              r_busy    <= 1'b1;
`ifdef DIV_UNIT_FAST_ZERO_EN
              if (b_i == 32'd0) begin
                r_state  <= S_DONE;
                r_valid  <= 1'b1;
                r_result <= ((w_op == CONTROL_DIV_OP_DIV) || (w_op == CONTROL_DIV_OP_DIVU))
                            ? 32'hFFFF_FFFF : a_i;
              end else begin
                r_state <= S_CALC;
              end
`else
              r_state <= S_CALC;
`endif
            end
          end
          S_CALC: begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'(DIV_ITERATIONS - 1)) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b1;
              r_result <= fixup(r_op, w_rem_n[31:0], w_quo_n, r_a_neg, r_b_neg, r_b_zero);
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o   = r_busy;
  assign valid_o  = r_valid;
  assign result_o = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases, random ops, flush, reset and back-to-back.
`timescale 1ns/1ps
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int n_chk = 0;
  int n_err = 0;

`ifdef DIV_UNIT_FAST_ZERO_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  always #5 clk = ~clk;

  div_unit dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .start_i       (start),
    .flush_i       (flush),
    .a_i           (a),
    .b_i           (b),
    .ctrl_div_op_i (op),
    .busy_o        (busy),
    .valid_o       (valid),
    .result_o      (result)
  );

  // RISC-V M-extension semantics straight from the ISA rules.
  function automatic logic [31:0] ref_model(input logic [1:0] op_v, input logic [31:0] a_v,
                                            input logic [31:0] b_v);
    logic signed [31:0] sa, sb, sr;
    bit ovf;
    sa  = a_v;
    sb  = b_v;
    ovf = (a_v == 32'h8000_0000) && (b_v == 32'hFFFF_FFFF);
    case (op_v)
      2'd0: begin
        if (b_v == 0) sr = -1;
        else if (ovf) sr = sa;
        else sr = sa / sb;
      end
      2'd1: begin
        if (b_v == 0) sr = -1;
        else sr = a_v / b_v;
      end
      2'd2: begin
        if (b_v == 0) sr = sa;
        else if (ovf) sr = 0;
        else sr = sa % sb;
      end
      default: begin
        if (b_v == 0) sr = sa;
        else sr = a_v % b_v;
      end
    endcase
    return sr;
  endfunction

  // Entered and left on a falling edge; start is sampled at the next rising edge.
  task automatic run_op(input string nm, input logic [1:0] op_v, input logic [31:0] a_v,
                        input logic [31:0] b_v);
    logic [31:0] exp;
    int exp_lat, lat;
    bit seen, busy_bad;
    exp     = ref_model(op_v, a_v, b_v);
    exp_lat = (FAST && b_v == 0) ? 1 : 33;
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    @(negedge clk);
    start = 1'b0;
    lat = 1; seen = 1'b0; busy_bad = 1'b0;
    while (lat <= 40) begin
      if (valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s timeout: valid_o not seen within 40 cycles (required latency %0d)", nm, exp_lat);
    end else begin
      n_chk++;
      if (lat !== exp_lat) begin
        n_err++;
        $display("FAIL %s latency: got %0d required %0d", nm, lat, exp_lat);
      end
      n_chk++;
      if (result !== exp) begin
        n_err++;
        $display("FAIL %s result: op=%0d a=%h b=%h got %h required %h", nm, op_v, a_v, b_v, result, exp);
      end
      n_chk++;
      if (busy !== 1'b1 || busy_bad) begin
        n_err++;
        $display("FAIL %s busy: busy_o low during operation (at valid %b) required 1", nm, busy);
      end
      @(negedge clk);
      n_chk++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s after_done: valid=%b busy=%b required 0 0", nm, valid, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b valid=%b result=%h required 0 0 0", busy, valid, result);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op("divu_100_7", 2'd1, 32'd100, 32'd7);
    run_op("remu_100_7", 2'd3, 32'd100, 32'd7);
    run_op("div_m7_2",   2'd0, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2",   2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_7_m2",   2'd2, 32'd7, 32'hFFFF_FFFE);
    run_op("div_ovf",    2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf",    2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_m5_0",   2'd0, 32'hFFFF_FFFB, 32'd0);
    run_op("remu_x_0",   2'd3, 32'h0000_1234, 32'd0);
    run_op("rem_neg_0",  2'd2, 32'h8765_4321, 32'd0);
    run_op("divu_max",   2'd1, 32'hFFFF_FFFF, 32'd1);
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    for (int i = 0; i < 24; i++) begin
      int sel;
      rop = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel <= 4) rb = 32'($urandom_range(1, 15));
      else if (sel == 5) rb = -32'($urandom_range(1, 15));
      run_op("random", rop, ra, rb);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_0", 2'd1, 32'd1000, 32'd10);
    run_op("b2b_1", 2'd0, 32'hFFFF_FC18, 32'd10);
    run_op("b2b_2", 2'd3, 32'd1001, 32'd10);
  endtask

  task automatic test_flush();
    logic [31:0] prior;
    bit vseen, bseen;
    prior = result;
    vseen = 1'b0;
    start = 1'b1; op = 2'd1; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) begin
      if (valid === 1'b1) vseen = 1'b1;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || valid !== 1'b0 || vseen) begin
      n_err++;
      $display("FAIL flush_abort: busy=%b valid=%b earlyvalid=%b required 0 0 0", busy, valid, vseen);
    end
    n_chk++;
    if (result !== prior) begin
      n_err++;
      $display("FAIL flush_result_held: got %h required %h", result, prior);
    end
    @(negedge clk);
    run_op("after_flush", 2'd1, 32'd100, 32'd7);

    prior = result;
    vseen = 1'b0; bseen = 1'b0;
    start = 1'b1; flush = 1'b1; op = 2'd3; a = 32'd55; b = 32'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    repeat (40) begin
      if (valid === 1'b1) vseen = 1'b1;
      if (busy === 1'b1) bseen = 1'b1;
      @(negedge clk);
    end
    n_chk++;
    if (vseen || bseen || result !== prior) begin
      n_err++;
      $display("FAIL start_flush_same: valid=%b busy=%b result=%h required 0 0 %h", vseen, bseen, result, prior);
    end
  endtask

  task automatic test_reset_mid();
    bit vseen, bseen;
    start = 1'b1; op = 2'd1; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_async: busy=%b valid=%b result=%h required 0 0 0", busy, valid, result);
    end
    @(negedge clk);
    reset_n = 1'b1;
    vseen = 1'b0; bseen = 1'b0;
    repeat (40) begin
      if (valid === 1'b1) vseen = 1'b1;
      if (busy === 1'b1) bseen = 1'b1;
      @(negedge clk);
    end
    n_chk++;
    if (vseen || bseen) begin
      n_err++;
      $display("FAIL reset_release_idle: valid=%b busy=%b required 0 0", vseen, bseen);
    end
    run_op("after_reset", 2'd1, 32'd9, 32'd3);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
